ucounter8_sched: RTL and testbench

- Round-robin scheduler that shares one external universal 8-bit counter/timer among NREQ timeout requesters.
- Each requester asks for a down-count of an 8-bit value, scaled by a common prescaler.
- The block arbitrates, preloads the counter, gates its count-enable, detects terminal count, and returns a one-cycle done pulse to the winner.
- It sits between the requester logic and the counter's control/data pins and is the only driver of those pins.

---
 rtl/ucounter8_sched.sv | 137 +++++++++++++
 tb/tb_ucounter8_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucounter8_sched.sv
// Round-robin owner of one shared 8-bit down-counter: grants one requester, preloads, paces ticks, pulses done.
// Grant 1 cycle after request; done at 3 + val*(presc+1); a requester waits in IDLE until the counter is free.
module ucounter8_sched #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              _areset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_val,
  input  logic [7:0]        presc,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              ctr_clr,
  output logic              ctr_load,
  output logic [7:0]        ctr_preld,
  output logic              ctr_updown,
  output logic              ctr_wrapstop,
  output logic              ctr_carry_in,
  input  logic [7:0]        ctr_dcount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [7:0]       val_q, val_d;
  logic [7:0]       presc_q, presc_d;
  logic [7:0]       pc_q, pc_d;

  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] win_nxt;
  logic             win_req;
  logic             tick;
  logic             cnt_zero;

  // Scan from the highest offset down so the closest pending requester to ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign win_nxt  = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
  assign win_req  = req[win_q];
  assign tick     = (pc_q == presc_q);
  assign cnt_zero = (ctr_dcount == 8'd0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    val_d   = val_q;
    presc_d = presc_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          val_d   = req_val[8*int'(pick_idx) +: 8];
          presc_d = presc;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pc_d    = 8'd0;
        state_d = win_req ? S_RUN : S_ABORT;
      end
      S_RUN: begin
        pc_d = tick ? 8'd0 : pc_q + 8'd1;
        // A withdrawn request beats terminal count: no done for a requester that left.
        if (!win_req) begin
          state_d = S_ABORT;
        end else if (cnt_zero) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_ABORT: begin
        grant_d = '0;
        ptr_d   = win_nxt;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      val_q   <= 8'd0;
      presc_q <= 8'd0;
      pc_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      val_q   <= val_d;
      presc_q <= presc_d;
      pc_q    <= pc_d;
    end
  end

  assign grant        = grant_q;
  assign done         = (state_q == S_DONE) ? (NREQ'(1) << win_q) : '0;
  assign busy         = (state_q != S_IDLE);
  assign ctr_clr      = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ABORT);
  assign ctr_load     = (state_q == S_LOAD);
  assign ctr_preld    = (state_q == S_LOAD) ? val_q : 8'd0;
  // Gating on a nonzero count keeps the counter from ever wrapping under zero.
  assign ctr_carry_in = (state_q == S_RUN) && tick && !cnt_zero;
  assign ctr_updown   = 1'b0;
  assign ctr_wrapstop = 1'b1;

endmodule

// File: tb/tb_ucounter8_sched.sv
// Bench for ucounter8_sched: behavioural counter, table-driven transactions, randomized traffic
// against a round-robin/latency reference model, and hand sequences for abort, fairness and reset.
module tb_ucounter8_sched;
  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_val;
  logic [7:0]        presc;
  logic [NREQ-1:0]   grant, done;
  logic              busy, ctr_clr, ctr_load, ctr_updown, ctr_wrapstop, ctr_carry_in;
  logic [7:0]        ctr_preld, ctr_dcount;
  logic [7:0]        cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int viol   = 0;
  int mptr;

  ucounter8_sched #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
    .clk(clk), ._areset(rst_n), .req(req), .req_val(req_val), .presc(presc),
    .grant(grant), .done(done), .busy(busy), .ctr_clr(ctr_clr), .ctr_load(ctr_load),
    .ctr_preld(ctr_preld), .ctr_updown(ctr_updown), .ctr_wrapstop(ctr_wrapstop),
    .ctr_carry_in(ctr_carry_in), .ctr_dcount(ctr_dcount)
  );

  always #5 clk = ~clk;

  // External universal counter: clear > load > count, stopping at the end of range when wrapstop is set.
  always @(posedge clk) begin
    if (ctr_clr) cnt <= 8'd0;
    else if (ctr_load) cnt <= ctr_preld;
    else if (ctr_carry_in) begin
      if (ctr_updown) cnt <= cnt + 8'd1;
      else if (!(ctr_wrapstop && cnt == 8'd0)) cnt <= cnt - 8'd1;
    end
  end
  assign ctr_dcount = cnt;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ctr_load && ctr_clr) viol <= viol + 1;
      if (ctr_carry_in && ctr_dcount == 8'd0) viol <= viol + 1;
      if (ctr_updown !== 1'b0 || ctr_wrapstop !== 1'b1) viol <= viol + 1;
      if ($countones(grant) > 1 || $countones(done) > 1) viol <= viol + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Observation c (1-based) shows the cycle after the c-th edge since req was applied.
  // drop_at: req cleared at observation drop_at, so the block sees it on the following edge.
  task automatic run_txn(input string nm, input logic [NREQ-1:0] r, input int win,
                         input int exp_done, input int exp_fall, input int drop_at,
                         input int exp_carry, input bit scramble);
    int done_at = -1;
    int fall_at = -1;
    int ncarry  = 0;
    logic [NREQ-1:0] done_val = '0;
    logic [NREQ-1:0] exp_grant;
    logic [7:0] exp_preld;
    exp_grant = NREQ'(1) << win;
    exp_preld = req_val[8*win +: 8];
    req = r;
    step();
    chk({nm, " grant"}, 32'(grant), 32'(exp_grant));
    chk({nm, " load"}, {31'd0, ctr_load}, 32'd1);
    chk({nm, " preld"}, 32'(ctr_preld), 32'(exp_preld));
    if (scramble) begin
      req_val = $urandom;
      presc   = 8'($urandom);
      req     = exp_grant | NREQ'($urandom);
    end
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) step();
      if (done != '0 && done_at < 0) begin
        done_at  = c;
        done_val = done;
      end
      if (ctr_carry_in) ncarry++;
      if (grant == '0) begin
        fall_at = c;
        break;
      end
      if (c == drop_at || c == done_at) req = '0;
    end
    req = '0;
    chk({nm, " done_cycle"}, 32'(done_at), 32'(exp_done));
    if (exp_done > 0) chk({nm, " done_val"}, 32'(done_val), 32'(exp_grant));
    chk({nm, " grant_fall"}, 32'(fall_at), 32'(exp_fall));
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
    if (exp_carry >= 0) chk({nm, " ticks"}, 32'(ncarry), 32'(exp_carry));
  endtask

  typedef struct {
    logic [NREQ-1:0] r;
    logic [7:0]      val;
    logic [7:0]      p;
    int              win;
    int              dcyc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int dcnt;
    tbl[0] = '{4'b0001, 8'd5, 8'd0,   0, 8};
    tbl[1] = '{4'b0001, 8'd3, 8'd2,   0, 12};
    tbl[2] = '{4'b0100, 8'd0, 8'd0,   2, 3};
    tbl[3] = '{4'b1010, 8'd2, 8'd1,   3, 7};
    tbl[4] = '{4'b0011, 8'd1, 8'd3,   0, 7};
    tbl[5] = '{4'b0011, 8'd1, 8'd0,   1, 4};
    tbl[6] = '{4'b0010, 8'd2, 8'd255, 1, 515};
    tbl[7] = '{4'b1001, 8'd4, 8'd1,   3, 11};

    req = '0;
    req_val = '0;
    presc = 8'd0;
    rst_n = 1'b0;
    #1;
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst clr", {31'd0, ctr_clr}, 32'd1);
    chk("rst load", {31'd0, ctr_load}, 32'd0);
    chk("rst carry", {31'd0, ctr_carry_in}, 32'd0);
    chk("rst preld", 32'(ctr_preld), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req_val = {NREQ{tbl[i].val}};
      presc   = tbl[i].p;
      run_txn($sformatf("tbl%0d", i), tbl[i].r, tbl[i].win, tbl[i].dcyc, tbl[i].dcyc + 1,
              -1, int'(tbl[i].val), 1'b0);
    end

    // Randomized traffic; the model only knows the round-robin rule and the latency formula.
    do_reset();
    mptr = 0;
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] r;
      logic [7:0] v[NREQ];
      int p, w, d, da, ed, ef;
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        v[i] = 8'($urandom_range(0, 15));
        req_val[8*i +: 8] = v[i];
      end
      p = $urandom_range(0, 3);
      presc = 8'(p);
      w = -1;
      for (int i = 0; i < NREQ; i++)
        if (w < 0 && r[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
      d = 3 + int'(v[w]) * (p + 1);
      if ($urandom_range(0, 3) == 0) begin
        da = $urandom_range(1, d - 1);
        ed = -1;
        ef = da + 2;
      end else begin
        da = -1;
        ed = d;
        ef = d + 1;
      end
      run_txn($sformatf("rnd%0d", it), r, w, ed, ef, da, (da < 0) ? int'(v[w]) : -1, 1'b1);
      mptr = (w + 1) % NREQ;
    end

    // Fairness with everyone asserted continuously.
    do_reset();
    req_val = {NREQ{8'd1}};
    presc = 8'd0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 20 && grant == '0; n++) step();
      chk($sformatf("rr grant%0d", k), 32'(grant), 32'(1 << (k % NREQ)));
      dcnt = 0;
      for (int n = 0; n < 20 && grant != '0; n++) begin
        if (done != '0) dcnt++;
        step();
      end
      chk($sformatf("rr dones%0d", k), 32'(dcnt), 32'd1);
    end
    req = '0;

    // Withdrawal mid-count.
    do_reset();
    req_val = {NREQ{8'd200}};
    presc = 8'd0;
    req = 4'b0100;
    step();
    chk("abort grant", 32'(grant), 32'b0100);
    for (int n = 2; n <= 10; n++) step();
    chk("abort dcount", 32'(ctr_dcount), 32'd192);
    req = '0;
    step();
    chk("abort clr", {31'd0, ctr_clr}, 32'd1);
    chk("abort done", 32'(done), 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd1);
    step();
    chk("abort fall", 32'(grant), 32'd0);
    req = 4'b1111;
    step();
    chk("abort next ptr", 32'(grant), 32'b1000);
    req = '0;

    // Reset in the middle of a long count.
    do_reset();
    req_val = {NREQ{8'd100}};
    req = 4'b0001;
    dcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done != '0) dcnt++;
    end
    chk("mid no done", 32'(dcnt), 32'd0);
    chk("mid busy before", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid rst grant", 32'(grant), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst clr", {31'd0, ctr_clr}, 32'd1);
    chk("mid rst carry", {31'd0, ctr_carry_in}, 32'd0);
    chk("mid rst load", {31'd0, ctr_load}, 32'd0);
    req = '0;
    step();
    chk("mid rst dcount", 32'(ctr_dcount), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mid rst idle", {31'd0, busy}, 32'd0);

    chk("protocol violations", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
